// File: rtl/rr_context_scheduler.sv
// Round-robin context scheduler: tracks ready process slots and their saved PCs,
// and sequences quantum expiry -> save -> select -> load -> re-arm.
module rr_context_scheduler #(
    parameter int NPROC = 8,
    parameter int PCW   = 16,
    localparam int IDW  = $clog2(NPROC)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           tmr_busy,
    input  logic           proc_set,
    input  logic           proc_clr,
    input  logic [IDW-1:0] proc_id,
    input  logic [PCW-1:0] pc_init,
    input  logic [PCW-1:0] cur_pc,
    output logic           arm_timer,
    output logic           switch_req,
    output logic           pc_load,
    output logic [PCW-1:0] pc_out,
    output logic [IDW-1:0] cur_pid,
    output logic           idle,
    output logic [2:0]     fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        SAVE   = 3'd2,
        SELECT = 3'd3,
        LOAD   = 3'd4,
        ARM    = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NPROC-1:0]     ready_mask;
    logic [PCW-1:0]       pc_table [NPROC];
    logic                 tmr_q;
    logic                 expiry;
    logic                 cur_ready;
    logic                 found;
    logic [IDW-1:0]       next_id;
    logic [IDW-1:0]       cand;

    assign expiry     = tmr_q && !tmr_busy;
    // A clear of the running slot counts in the same cycle so it pre-empts a
    // simultaneous expiry (the exiting process is never saved).
    assign cur_ready  = ready_mask[cur_pid] && !(proc_clr && (proc_id == cur_pid));

    assign idle       = (state == IDLE);
    assign switch_req = (state == SAVE) || (state == SELECT) || (state == LOAD) || (state == ARM);
    assign pc_load    = (state == LOAD);
    assign arm_timer  = (state == ARM);
    assign fsm_state  = state;

    // Search starts after the current slot and wraps; the current slot is checked last.
    always_comb begin
        found   = 1'b0;
        next_id = cur_pid;
        cand    = cur_pid;
        for (int k = 1; k <= NPROC; k++) begin
            cand = IDW'((int'(cur_pid) + k) % NPROC);
            if (!found && ready_mask[cand]) begin
                found   = 1'b1;
                next_id = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && (ready_mask != '0)) state_nxt = SELECT;
            end
            RUN: begin
                if (!cur_ready)   state_nxt = SELECT;
                else if (expiry)  state_nxt = start ? SAVE : IDLE;
            end
            SAVE:    state_nxt = SELECT;
            SELECT:  state_nxt = found ? LOAD : IDLE;
            LOAD:    state_nxt = ARM;
            ARM:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Cleared on the way out of ARM so a level left over from the last quantum
    // cannot look like an immediate expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               tmr_q <= 1'b0;
        else if (state == ARM)   tmr_q <= 1'b0;
        else                     tmr_q <= tmr_busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_mask <= '0;
        end else begin
            if (proc_set) ready_mask[proc_id] <= 1'b1;
            if (proc_clr) ready_mask[proc_id] <= 1'b0;
        end
    end

    // The SAVE write is issued last so it overrides a same-slot proc_set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPROC; i++) pc_table[i] <= '0;
        end else begin
            if (proc_set)      pc_table[proc_id] <= pc_init;
            if (state == SAVE) pc_table[cur_pid] <= cur_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_pid <= '0;
            pc_out  <= '0;
        end else if ((state == SELECT) && found) begin
            cur_pid <= next_id;
            pc_out  <= pc_table[next_id];
        end
    end

endmodule

// File: tb/tb_rr_context_scheduler.sv
// Directed bench for rr_context_scheduler: a per-cycle vector table for the main
// round-robin flow, then hand sequences for clear-priority, start-fall and reset.
module tb_rr_context_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        tmr_busy;
    logic        proc_set;
    logic        proc_clr;
    logic [2:0]  proc_id;
    logic [15:0] pc_init;
    logic [15:0] cur_pc;
    logic        arm_timer;
    logic        switch_req;
    logic        pc_load;
    logic [15:0] pc_out;
    logic [2:0]  cur_pid;
    logic        idle;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd3;

    typedef struct {
        logic        s, b, set, clr;
        logic [2:0]  id;
        logic [15:0] pinit, cpc;
        logic        arm, sw, ld, idl;
        logic [2:0]  pid;
        logic [15:0] pc;
    } vec_t;

    vec_t vq[$];

    rr_context_scheduler #(.NPROC(8), .PCW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .tmr_busy(tmr_busy),
        .proc_set(proc_set), .proc_clr(proc_clr), .proc_id(proc_id),
        .pc_init(pc_init), .cur_pc(cur_pc), .arm_timer(arm_timer),
        .switch_req(switch_req), .pc_load(pc_load), .pc_out(pc_out),
        .cur_pid(cur_pid), .idle(idle), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock, then settle past the edge.
    task automatic step(input logic s, input logic b, input logic set, input logic clr,
                        input logic [2:0] id, input logic [15:0] pinit, input logic [15:0] cpc);
        start    = s;
        tmr_busy = b;
        proc_set = set;
        proc_clr = clr;
        proc_id  = id;
        pc_init  = pinit;
        cur_pc   = cpc;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic b, input logic set, input logic clr,
                       input logic [2:0] id, input logic [15:0] pinit, input logic [15:0] cpc,
                       input logic arm, input logic sw, input logic ld, input logic idl,
                       input logic [2:0] pid, input logic [15:0] pc);
        vec_t v;
        v.s = s; v.b = b; v.set = set; v.clr = clr; v.id = id; v.pinit = pinit; v.cpc = cpc;
        v.arm = arm; v.sw = sw; v.ld = ld; v.idl = idl; v.pid = pid; v.pc = pc;
        vq.push_back(v);
    endtask

    function automatic logic [31:0] outs(input logic arm, input logic sw, input logic ld,
                                         input logic idl, input logic [2:0] pid, input logic [15:0] pc);
        return {9'd0, arm, sw, ld, idl, pid, pc};
    endfunction

    initial begin
        int          sw_cnt;
        logic        done;
        logic [15:0] seen_pc;
        logic [2:0]  seen_pid;
        int          pulses;

        reset = 1'b1; start = 0; tmr_busy = 0; proc_set = 0; proc_clr = 0;
        proc_id = 0; pc_init = 0; cur_pc = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(arm_timer, switch_req, pc_load, idle, cur_pid, pc_out),
              outs(0, 0, 0, 1, 3'd0, 16'h0000));
        reset = 1'b0;

        //   s  b  set clr id  pinit     cpc       arm sw ld idl pid pc
        add(0, 0, 1, 0, 3, 16'h0100, 16'h0000, 0, 0, 0, 1, 0, 16'h0000);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
        add(1, 0, 1, 0, 1, 16'h0010, 16'h0000, 0, 1, 1, 0, 3, 16'h0100);
        add(1, 0, 1, 0, 6, 16'h0600, 16'h0000, 1, 1, 0, 0, 3, 16'h0100);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3, 16'h0100);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3, 16'h0100);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0ABC, 0, 1, 0, 0, 3, 16'h0100);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0ABC, 0, 1, 0, 0, 3, 16'h0100);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 6, 16'h0600);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 6, 16'h0600);
        add(1, 1, 1, 1, 4, 16'h0444, 16'h0000, 0, 0, 0, 0, 6, 16'h0600);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 6, 16'h0600);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0666, 0, 1, 0, 0, 6, 16'h0600);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0666, 0, 1, 0, 0, 6, 16'h0600);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 1, 16'h0010);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 1, 16'h0010);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h0010);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h0010);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0111, 0, 1, 0, 0, 1, 16'h0010);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0111, 0, 1, 0, 0, 1, 16'h0010);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 3, 16'h0ABC);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 3, 16'h0ABC);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3, 16'h0ABC);
        add(1, 1, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 3, 16'h0ABC);
        add(1, 1, 0, 1, 6, 16'h0000, 16'h0000, 0, 0, 0, 0, 3, 16'h0ABC);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0333, 0, 1, 0, 0, 3, 16'h0ABC);
        add(1, 0, 1, 0, 3, 16'h0DEA, 16'h0333, 0, 1, 0, 0, 3, 16'h0ABC);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 3, 16'h0333);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 3, 16'h0333);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3, 16'h0333);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].s, vq[i].b, vq[i].set, vq[i].clr, vq[i].id, vq[i].pinit, vq[i].cpc);
            check($sformatf("vec%0d", i), outs(arm_timer, switch_req, pc_load, idle, cur_pid, pc_out),
                  outs(vq[i].arm, vq[i].sw, vq[i].ld, vq[i].idl, vq[i].pid, vq[i].pc));
        end

        // Clear of the running slot in the expiry cycle: straight to SELECT, then IDLE.
        step(1, 1, 0, 0, 0, 16'h0000, 16'h0000);
        step(1, 0, 0, 1, 3, 16'h0000, 16'h0BAD);
        check("clr_prio_state", {29'd0, fsm_state}, {29'd0, ST_SELECT});
        step(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        check("clr_empty_idle", {30'd0, idle, switch_req}, {30'd0, 1'b1, 1'b0});

        // Single ready slot reselects itself after expiry with its saved PC.
        step(1, 0, 1, 0, 5, 16'h0500, 16'h0000);
        step(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        step(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        check("slot5_first_load", outs(arm_timer, switch_req, pc_load, idle, cur_pid, pc_out),
              outs(0, 1, 1, 0, 3'd5, 16'h0500));
        step(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        step(1, 1, 0, 0, 0, 16'h0000, 16'h0000);
        step(1, 1, 0, 0, 0, 16'h0000, 16'h0000);
        step(1, 0, 0, 0, 0, 16'h0000, 16'h5A5A);
        sw_cnt = 0; done = 0; seen_pc = '0; seen_pid = '0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (pc_load) begin
                seen_pc  = pc_out;
                seen_pid = cur_pid;
            end
            if (!switch_req) done = 1;
            else begin
                sw_cnt++;
                step(1, 0, 0, 0, 0, 16'h0000, 16'h5A5A);
            end
        end
        check("switch_done", {31'd0, done}, 32'd1);
        check("switch_cycles", sw_cnt, 4);
        check("reselect_pc", {13'd0, seen_pid, seen_pc}, {13'd0, 3'd5, 16'h5A5A});

        // With start low, the next expiry goes to IDLE rather than SAVE.
        step(0, 1, 0, 0, 0, 16'h0000, 16'h0000);
        step(0, 0, 0, 0, 0, 16'h0000, 16'h1234);
        check("start_low_idle", {28'd0, idle, fsm_state}, {28'd0, 1'b1, ST_IDLE});

        // Reset in LOAD clears everything at once; nothing fires until a slot is ready again.
        step(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        step(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        check("pre_reset_load", outs(arm_timer, switch_req, pc_load, idle, cur_pid, pc_out),
              outs(0, 1, 1, 0, 3'd5, 16'h5A5A));
        #2 reset = 1'b1;
        #1;
        check("async_reset", outs(arm_timer, switch_req, pc_load, idle, cur_pid, pc_out),
              outs(0, 0, 0, 1, 3'd0, 16'h0000));
        step(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
            if (pc_load || arm_timer || !idle) pulses++;
        end
        check("no_pulse_after_reset", pulses, 0);
        step(1, 0, 1, 0, 2, 16'h0222, 16'h0000);
        step(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        step(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        check("post_reset_load", outs(arm_timer, switch_req, pc_load, idle, cur_pid, pc_out),
              outs(0, 1, 1, 0, 3'd2, 16'h0222));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_context_scheduler.md
RR_CONTEXT_SCHEDULER -- requirements
Module: rr_context_scheduler

Interface
REQ-001 Parameter: NPROC, 8, number of process slots (process ID width 3 bits).
REQ-002 Parameter: PCW, 16, program-counter width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  kernel enable; scheduling leaves IDLE only while start=1.
REQ-006 tmr_busy  input  1  quantum-timer active flag; high while a quantum runs.
REQ-007 proc_set  input  1  marks slot proc_id ready and loads its PC from pc_init.
REQ-008 proc_clr  input  1  marks slot proc_id not ready (process exit or block).
REQ-009 proc_id  input  3  slot addressed by proc_set/proc_clr.
REQ-010 pc_init  input  PCW  initial PC written on proc_set.
REQ-011 cur_pc  input  PCW  live PC of the running process, sampled in SAVE.
REQ-012 arm_timer  output  1  one-cycle pulse that starts a new quantum.
REQ-013 switch_req  output  1  holds the core stalled during a context switch.
REQ-014 pc_load  output  1  one-cycle pulse; core loads pc_out.
REQ-015 pc_out  output  PCW  PC of the newly selected process.
REQ-016 cur_pid  output  3  ID of the running or last-selected process.
REQ-017 idle  output  1  high while the FSM is in IDLE.

Function
REQ-018 The block SHALL hold an internal ready mask of NPROC bits and a PC table of NPROC x PCW registers.
REQ-019 The FSM SHALL use exactly these states: IDLE, RUN, SAVE, SELECT, LOAD, ARM.
REQ-020 IDLE: idle=1; the FSM SHALL go to SELECT when start=1 and the ready mask is nonzero; otherwise it stays in IDLE.
REQ-021 RUN: the block SHALL register tmr_busy into tmr_q every cycle and detect expiry as tmr_q=1 and tmr_busy=0; on expiry it goes to SAVE.
REQ-022 RUN: if the ready bit of cur_pid is cleared, the block SHALL go directly to SELECT without saving; this takes priority over expiry in the same cycle.
REQ-023 SAVE: the block SHALL write cur_pc into table[cur_pid] and then go to SELECT.
REQ-024 SELECT: the block SHALL search slots cur_pid+1, cur_pid+2, ... wrapping modulo NPROC, with cur_pid checked last, and take the first ready slot.
REQ-025 SELECT: with no ready slot, the FSM SHALL go to IDLE; otherwise it latches the next ID and goes to LOAD.
REQ-026 LOAD: the block SHALL set cur_pid to the next ID, drive pc_out with table[next], assert pc_load for this single cycle, and go to ARM.
REQ-027 ARM: the block SHALL assert arm_timer for this single cycle, go to RUN, and clear tmr_q so that a stale tmr_busy level cannot trigger a false expiry.
REQ-028 switch_req SHALL be high in SAVE, SELECT, LOAD and ARM, and low in IDLE and RUN.
REQ-029 Expiry latency SHALL be fixed: expiry detected in cycle N -> SAVE N+1, SELECT N+2, LOAD N+3 (pc_load), ARM N+4 (arm_timer), RUN N+5.
REQ-030 proc_set and proc_clr SHALL be accepted in every state; when both target the same slot in the same cycle, clr wins and the mask bit is 0.
REQ-031 If a proc_set table write and the SAVE write target the same slot in the same cycle, the SAVE write SHALL win.
REQ-032 A mask change made during SELECT SHALL take effect in the next search, not in the search in progress.
REQ-033 pc_out SHALL hold its value between LOAD pulses.
REQ-034 When start falls, the block SHALL finish any switch in progress, then go to IDLE at the next expiry instead of SAVE; IDLE keeps the table and mask.

Reset
REQ-035 On reset assertion, asynchronously: state=IDLE, ready mask=0, PC table=0, tmr_q=0, cur_pid=0, pc_out=0, arm_timer=0, pc_load=0, switch_req=0, idle=1.
REQ-036 Reset asserted mid-switch SHALL abort the switch with no partial table write; normal operation resumes on the first clock edge after reset deasserts.

Verification
REQ-037 Reset, then proc_set id3 pc_init=0x0100, then start=1 -> SELECT picks 3; pc_load pulse with pc_out=0x0100, cur_pid=3; next cycle arm_timer pulse.
REQ-038 Slots 1, 3, 6 ready; cur_pid=3; tmr_busy falls with cur_pc=0x0ABC -> table[3]=0x0ABC; pc_load 3 cycles later with cur_pid=6; next expiry selects 1 (wrap-around).
REQ-039 Only slot 5 ready and running; expiry -> slot 5 reselected, pc_out equals the saved cur_pc; switch_req high for exactly 4 cycles.
REQ-040 Running slot 2 with proc_clr id2 and expiry in the same cycle -> no SAVE write, goes to SELECT; with no other slot ready -> IDLE, idle=1.
REQ-041 proc_set and proc_clr on id4 in the same cycle -> mask bit 4 = 0; slot 4 is never selected.
REQ-042 Reset asserted in LOAD -> all outputs take reset values immediately; table=0; no pc_load or arm_timer pulse after reset deasserts until start=1 and the mask is nonzero.
